// File: rtl/ila_capture_ctrl.sv
// ila_capture_ctrl: pre/post-trigger capture sequencer for the ILA sample FIFO; ILA_FORCE_TRIGGER_EN adds force_trig_i.
// Push/pop are combinational (0 cycles), state and status are registered (1 cycle); fifo_full_i blocks pushes and ends capture as overflow.
module ila_capture_ctrl #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 15
) (
    input  logic             wclk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             sample_en_i,
    input  logic [CNT_W-1:0] pre_trig_i,
    input  logic [CNT_W-1:0] post_trig_i,
    input  logic [WIDTH-1:0] trig_data_i,
    input  logic [WIDTH-1:0] trig_pattern_i,
    input  logic [WIDTH-1:0] trig_mask_i,
    input  logic             trig_edge_i,
`ifdef ILA_FORCE_TRIGGER_EN
    input  logic             force_trig_i,
`endif
    input  logic             fifo_full_i,
    input  logic             fifo_empty_i,
    input  logic             rd_req_i,
    output logic             fifo_push_o,
    output logic             fifo_pop_o,
    output logic             busy_o,
    output logic             triggered_o,
    output logic             done_o,
    output logic             overflow_o,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4,
        ST_FLUSH = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_pre_lat;
    logic [CNT_W-1:0] r_post_lat;
    logic [CNT_W-1:0] r_pre_cnt;
    logic [CNT_W-1:0] r_post_cnt;
    logic             r_triggered;
    logic             r_overflow;
    logic             r_match_prev;

    logic             w_active;
    logic             w_match;
    logic             w_force;
    logic             w_trig;
    logic             w_ovf;
    logic             w_push;
    logic             w_pre_hit;
    logic             w_post_hit;

    assign w_active   = (r_state == ST_PRE) || (r_state == ST_ARMED) || (r_state == ST_POST);
    assign w_match    = (((trig_data_i ^ trig_pattern_i) & trig_mask_i) == '0);
`ifdef ILA_FORCE_TRIGGER_EN
    assign w_force    = force_trig_i;
`else
    assign w_force    = 1'b0;
`endif
    assign w_trig     = (r_state == ST_ARMED) && sample_en_i &&
                        (w_force || (trig_edge_i ? (w_match && !r_match_prev) : w_match));
    assign w_ovf      = w_active && sample_en_i && fifo_full_i;
    assign w_push     = w_active && sample_en_i && !fifo_full_i;
    assign w_pre_hit  = ((r_pre_cnt + CNT_W'(1)) == r_pre_lat);
    assign w_post_hit = ((r_post_cnt + CNT_W'(1)) == r_post_lat);

    always_ff @(posedge wclk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Abort outranks overflow, which outranks trigger/count progress.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_next_state = (pre_trig_i == '0) ? ST_ARMED : ST_PRE;
                end
            end
            ST_PRE: begin
                if (abort_i)                  w_next_state = ST_FLUSH;
                else if (w_ovf)               w_next_state = ST_DONE;
                else if (w_push && w_pre_hit) w_next_state = ST_ARMED;
            end
            ST_ARMED: begin
                if (abort_i)     w_next_state = ST_FLUSH;
                else if (w_ovf)  w_next_state = ST_DONE;
                else if (w_trig) w_next_state = (r_post_lat == '0) ? ST_DONE : ST_POST;
            end
            ST_POST: begin
                if (abort_i)                   w_next_state = ST_FLUSH;
                else if (w_ovf)                w_next_state = ST_DONE;
                else if (w_push && w_post_hit) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                if (start_i) w_next_state = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (fifo_empty_i) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // A pop in ARMED keeps the window fixed; an empty FIFO drops it and the window grows.
    always_comb begin
        fifo_push_o = w_push;
        fifo_pop_o  = 1'b0;
        case (r_state)
            ST_ARMED: fifo_pop_o = w_push && !w_trig && !fifo_empty_i;
            ST_DONE:  fifo_pop_o = rd_req_i && !fifo_empty_i;
            ST_FLUSH: fifo_pop_o = !fifo_empty_i;
            default:  fifo_pop_o = 1'b0;
        endcase
        busy_o  = (r_state != ST_IDLE) && (r_state != ST_DONE);
        done_o  = (r_state == ST_DONE);
        state_o = r_state;
    end

    assign triggered_o = r_triggered;
    assign overflow_o  = r_overflow;

    always_ff @(posedge wclk) begin
        if (rst) begin
            r_pre_lat    <= '0;
            r_post_lat   <= '0;
            r_pre_cnt    <= '0;
            r_post_cnt   <= '0;
            r_triggered  <= 1'b0;
            r_overflow   <= 1'b0;
            r_match_prev <= 1'b0;
        end else begin
            if (sample_en_i) begin
                r_match_prev <= w_match;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_pre_lat   <= pre_trig_i;
                        r_post_lat  <= post_trig_i;
                        r_pre_cnt   <= '0;
                        r_post_cnt  <= '0;
                        r_triggered <= 1'b0;
                        r_overflow  <= 1'b0;
                    end
                end
                ST_PRE: begin
                    if (w_push && !abort_i) begin
                        r_pre_cnt <= r_pre_cnt + CNT_W'(1);
                    end
                end
                ST_ARMED: begin
                    if (w_trig && !abort_i && !w_ovf) begin
                        r_triggered <= 1'b1;
                        r_post_cnt  <= '0;
                    end
                end
                ST_POST: begin
                    if (w_push && !abort_i) begin
                        r_post_cnt <= r_post_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
            if (w_ovf && !abort_i) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
